// File: rtl/match_filter_ctrl.sv
// RX match filter sequencer: streams coefficients into match_filter, arms it,
// qualifies match detections with a post-match holdoff and keeps match statistics.
module match_filter_ctrl #(
  parameter int unsigned NUM_COEF = 7,
  parameter int unsigned HOLDOFF  = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             disarm,
  input  logic [31:0]      cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             rxstrobe,
  output logic             mf_strobe,
  output logic [31:0]      cdata,
  output logic [2:0]       cstate,
  output logic             cwrite,
  input  logic             mf_valid,
  input  logic             mf_match,
  output logic             armed,
  output logic             coef_ok,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] match_idx
);

  localparam int unsigned HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [2:0]        LAST_IDX  = 3'(NUM_COEF - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_ARMED   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                cfg_ready_d, cwrite_d, armed_d, coef_ok_d, match_pulse_d;
  logic [31:0]         cdata_d;
  logic [2:0]          cstate_d;
  logic [CNT_W-1:0]    match_count_d, match_idx_d;
  logic [CNT_W-1:0]    sample_idx_q, sample_idx_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                cfg_hs;
  logic                match_hit;

  assign cfg_hs    = cfg_valid & cfg_ready;
  assign match_hit = mf_valid & mf_match;
  // Strobe gating follows the registered armed flag.
  assign mf_strobe = rxstrobe & armed;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cfg_ready    <= 1'b0;
      cdata        <= '0;
      cstate       <= '0;
      cwrite       <= 1'b0;
      armed        <= 1'b0;
      coef_ok      <= 1'b0;
      match_pulse  <= 1'b0;
      match_count  <= '0;
      match_idx    <= '0;
      sample_idx_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_ready    <= cfg_ready_d;
      cdata        <= cdata_d;
      cstate       <= cstate_d;
      cwrite       <= cwrite_d;
      armed        <= armed_d;
      coef_ok      <= coef_ok_d;
      match_pulse  <= match_pulse_d;
      match_count  <= match_count_d;
      match_idx    <= match_idx_d;
      sample_idx_q <= sample_idx_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Next-state and next-output logic; disarm has priority over everything else.
  always_comb begin
    state_d       = state_q;
    cfg_ready_d   = cfg_ready;
    cdata_d       = cdata;
    cstate_d      = cstate;
    cwrite_d      = 1'b0;
    armed_d       = armed;
    coef_ok_d     = coef_ok;
    match_pulse_d = 1'b0;
    match_count_d = match_count;
    match_idx_d   = match_idx;
    sample_idx_d  = sample_idx_q;
    hold_cnt_d    = hold_cnt_q;

    if (disarm) begin
      state_d     = S_IDLE;
      armed_d     = 1'b0;
      cfg_ready_d = 1'b0;
    end else if (load_start && (state_q != S_LOAD)) begin
      state_d     = S_LOAD;
      cstate_d    = '0;
      coef_ok_d   = 1'b0;
      cfg_ready_d = 1'b1;
      armed_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end

        S_LOAD: begin
          if (cfg_hs) begin
            cdata_d  = cfg_data;
            cstate_d = cstate + 3'd1;
            cwrite_d = 1'b1;
            if (cstate == LAST_IDX) begin
              state_d       = S_ARMED;
              cfg_ready_d   = 1'b0;
              coef_ok_d     = 1'b1;
              armed_d       = 1'b1;
              match_count_d = '0;
              sample_idx_d  = '0;
              hold_cnt_d    = '0;
            end
          end
        end

        S_ARMED: begin
          if (rxstrobe) sample_idx_d = sample_idx_q + CNT_W'(1);
          // Latch the pre-increment index when a match shares a strobe cycle.
          if (match_hit) begin
            match_pulse_d = 1'b1;
            match_idx_d   = sample_idx_q;
            if (match_count != CNT_MAX) match_count_d = match_count + CNT_W'(1);
            state_d       = S_HOLDOFF;
            hold_cnt_d    = HOLD_INIT;
          end
        end

        S_HOLDOFF: begin
          if (rxstrobe) sample_idx_d = sample_idx_q + CNT_W'(1);
          if (hold_cnt_q == '0) begin
            state_d = S_ARMED;
          end else if (rxstrobe) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            if (hold_cnt_q == HOLD_W'(1)) state_d = S_ARMED;
          end
        end

        default: begin
          state_d     = S_IDLE;
          armed_d     = 1'b0;
          cfg_ready_d = 1'b0;
        end
      endcase
    end
  end

endmodule
